note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Plays a melody stored in a synchronous song ROM by driving the 10-bit `note` input of the note decoder.
- Each ROM entry holds a note and its duration in tempo ticks. A duration of 0 marks the end of the song.
- Sequences fetch, play and inter-note gap per entry. Reports busy/done to the top-level control (buttons/switches).
- Sits between the song ROM and note_decoder. The gate output mutes the amplitude path during rests and gaps.

Parameters:
- ADDR_W, 8, song ROM address width (max 2^ADDR_W entries).
- DUR_W, 6, duration field width in ticks.
- TICK_DIV, 4, clk cycles per tempo tick (>=1).
- GAP_CYC, 2, clk cycles of gate-low release between notes (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level/pulse; begins playback from address 0 when idle
- stop  in  1  aborts playback
- loop  in  1  when 1, end marker restarts at address 0 instead of finishing
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  10+DUR_W  {note[9:0], dur[DUR_W-1:0]}; registered ROM, valid 1 cycle after rom_addr
- note  out  10  note to note_decoder; 0 = rest
- gate  out  1  1 = sound enabled
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on natural song end

Behaviour:
- All outputs are registered.
- Reset (any state, mid-note included) applies on the next edge:
  - state IDLE
  - rom_addr 0, note 0, gate 0, busy 0, done 0
  - tick and duration counters 0
- States: IDLE, FETCH, LATCH, PLAY, GAP.
- IDLE: start=1 at edge t -> FETCH at t+1 with rom_addr=current addr (0 after idle).
- FETCH: one cycle, waits out the ROM latency -> LATCH.
- LATCH: capture rom_data.
  - dur==0 and loop=1: addr<=0 -> FETCH.
  - dur==0 and loop=0: -> IDLE; done=1 for exactly the next cycle; busy low that same cycle; addr<=0.
  - dur!=0: note<=data note; gate<=(note!=0); load counters -> PLAY.
- PLAY: lasts exactly dur*TICK_DIV cycles.
  - Tick counter counts 0..TICK_DIV-1 and wraps, decrementing the duration counter on wrap.
  - Leave PLAY when the last tick completes -> GAP.
- GAP:
  - gate=0, note held.
  - Lasts GAP_CYC cycles.
  - Then addr<=addr+1 (wraps 2^ADDR_W-1 -> 0, no end implied) -> FETCH.
- Latency: start at cycle t -> note/gate valid at t+3.
- Entry period: 2 + dur*TICK_DIV + GAP_CYC cycles.
- stop=1 in any state: next cycle IDLE, note 0, gate 0, addr 0, done stays 0.
  - stop and start asserted together: stop wins.
- start while busy is ignored. A held start re-triggers only from IDLE, so a held start after done restarts the song.
- loop is sampled only in LATCH on the end marker.
- An end marker at address 0 with loop=1 loops FETCH/LATCH forever with gate 0. This is legal and exits via stop/reset.

Test Plan:
- TICK_DIV=4, GAP_CYC=2.
- ROM = [0]{57,2}, [1]{0,1}, [2]{x,0}; start pulse at cycle 0, loop=0. Required response:
  - rom_addr=0 at cycle 1.
  - note=57, gate=1 on cycles 3-10.
  - gate=0, note=57 on cycles 11-12.
  - note=0, gate=0 on cycles 15-18.
  - done=1 only at cycle 23; busy 1 on cycles 1-22, 0 at 23.
- Same ROM, loop=1: after the end marker at LATCH (cycle 22), rom_addr=0 at cycle 23 and note=57 again at cycle 25; done never asserts.
- Stop at cycle 6 during the first note: cycle 7 shows gate=0, note=0, busy=0, rom_addr=0. A following start replays from entry 0 with note=57 three cycles later.
- Reset asserted at cycle 8 mid-PLAY together with start: all outputs 0 at cycle 9, state IDLE. Start applied after reset deasserts is required to begin playback.
- ADDR_W=2, ROM filled with {5,1} and no end marker: rom_addr sequence 0,1,2,3,0,1 … with each note lasting 4 cycles; done never pulses. Start pulses during playback do not change rom_addr.
- start and stop high together from IDLE: remains IDLE, busy=0, rom_addr=0.

Source files
------------

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - song ROM read bus between note_sequencer and its ROM
interface note_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 6
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [9+DUR_W:0]   rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps through song ROM entries {note, dur}, driving note/gate
module note_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DUR_W    = 6,
    parameter int TICK_DIV = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    note_sequencer_if.master    rom,
    output logic [9:0]          note,
    output logic                gate,
    output logic                busy,
    output logic                done
);
    // One counter serves both the tick divider in PLAY and the release timer in GAP.
    localparam int CNT_MAX = (TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    tick_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic [9:0]          rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign {rom_note, rom_dur} = rom.rom_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rom.rom_addr <= '0;
            note         <= '0;
            gate         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tick_cnt     <= '0;
            dur_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state        <= IDLE;
                rom.rom_addr <= '0;
                note         <= '0;
                gate         <= 1'b0;
                busy         <= 1'b0;
                tick_cnt     <= '0;
                dur_cnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    FETCH: state <= LATCH;
                    LATCH: begin
                        if (rom_dur == '0) begin
                            rom.rom_addr <= '0;
                            if (loop) begin
                                state <= FETCH;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                note  <= '0;
                            end
                        end else begin
                            note     <= rom_note;
                            gate     <= (rom_note != '0);
                            tick_cnt <= '0;
                            dur_cnt  <= rom_dur;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
                            tick_cnt <= '0;
                            dur_cnt  <= dur_cnt - 1'b1;
                            if (dur_cnt == DUR_W'(1)) begin
                                gate  <= 1'b0;
                                state <= GAP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (tick_cnt == CNT_W'(GAP_CYC - 1)) begin
                            tick_cnt     <= '0;
                            rom.rom_addr <= rom.rom_addr + 1'b1;
                            state        <= FETCH;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
